// File: rtl/mips_alu_pkg.sv
// rtl/mips_alu_pkg.sv - funct codes and mul/div FSM encoding for mips_alu_seq
package mips_alu_pkg;

   localparam logic [5:0] FN_SLL   = 6'b000000;
   localparam logic [5:0] FN_SRL   = 6'b000010;
   localparam logic [5:0] FN_SRA   = 6'b000011;
   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MFLO  = 6'b010010;
   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_DIV   = 6'b011010;
   localparam logic [5:0] FN_DIVU  = 6'b011011;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_XOR   = 6'b100110;
   localparam logic [5:0] FN_NOR   = 6'b100111;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_SLTU  = 6'b101011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } md_state_t;

endpackage

// File: rtl/mips_muldiv_seq.sv
// rtl/mips_muldiv_seq.sv - iterative shift-add multiplier / restoring divider
// i_op: bit1 = divide, bit0 = unsigned. Works on magnitudes; signs applied in FIX.
module mips_muldiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_idle,
   output logic             o_done,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo,
   output logic             o_div0
);
   import mips_alu_pkg::*;

   localparam int CNT_W = $clog2(WIDTH);

   md_state_t        r_state, w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_hw, r_lw, r_dsr;
   logic             r_neg_q, r_neg_r, r_div0, r_is_div;

   logic             w_sgn, w_bzero;
   logic [WIDTH-1:0] w_mag_a, w_mag_b;
   logic [WIDTH:0]   w_madd, w_dsh, w_dsub;
   logic [2*WIDTH-1:0] w_prod;

   assign w_sgn   = ~i_op[0];
   assign w_bzero = (i_b == '0);
   assign w_mag_a = (w_sgn && i_a[WIDTH-1]) ? -i_a : i_a;
   assign w_mag_b = (w_sgn && i_b[WIDTH-1]) ? -i_b : i_b;

   // {r_hw,r_lw} is the product register (mul) or {remainder,quotient} (div)
   assign w_madd = {1'b0, r_hw} + (r_lw[0] ? {1'b0, r_dsr} : {(WIDTH+1){1'b0}});
   assign w_dsh  = {r_hw, r_lw[WIDTH-1]};
   assign w_dsub = w_dsh - {1'b0, r_dsr};
   assign w_prod = r_neg_q ? -{r_hw, r_lw} : {r_hw, r_lw};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               if (i_op[1] && w_bzero) w_next = ST_FIX;
               else if (i_op[1])       w_next = ST_DIV;
               else                    w_next = ST_MUL;
            end
         end
         ST_MUL, ST_DIV: begin
            if (r_cnt == '0) w_next = ST_FIX;
         end
         ST_FIX:  w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt    <= '0;
         r_hw     <= '0;
         r_lw     <= '0;
         r_dsr    <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_div0   <= 1'b0;
         r_is_div <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_cnt    <= CNT_W'(WIDTH-1);
                  r_is_div <= i_op[1];
                  r_div0   <= i_op[1] & w_bzero;
                  r_dsr    <= w_mag_b;
                  if (i_op[1] && w_bzero) begin
                     r_hw    <= i_a;
                     r_lw    <= '1;
                     r_neg_q <= 1'b0;
                     r_neg_r <= 1'b0;
                  end else begin
                     r_hw    <= '0;
                     r_lw    <= w_mag_a;
                     r_neg_q <= w_sgn & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                     r_neg_r <= w_sgn & i_a[WIDTH-1] & i_op[1];
                  end
               end
            end
            ST_MUL: begin
               r_hw  <= w_madd[WIDTH:1];
               r_lw  <= {w_madd[0], r_lw[WIDTH-1:1]};
               r_cnt <= r_cnt - 1'b1;
            end
            ST_DIV: begin
               if (!w_dsub[WIDTH]) begin
                  r_hw <= w_dsub[WIDTH-1:0];
                  r_lw <= {r_lw[WIDTH-2:0], 1'b1};
               end else begin
                  r_hw <= w_dsh[WIDTH-1:0];
                  r_lw <= {r_lw[WIDTH-2:0], 1'b0};
               end
               r_cnt <= r_cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      o_hi = w_prod[2*WIDTH-1:WIDTH];
      o_lo = w_prod[WIDTH-1:0];
      if (r_is_div) begin
         o_hi = r_neg_r ? -r_hw : r_hw;
         o_lo = r_neg_q ? -r_lw : r_lw;
      end
   end

   assign o_idle = (r_state == ST_IDLE);
   assign o_done = (r_state == ST_FIX);
   assign o_div0 = r_div0;

endmodule

// File: rtl/mips_alu_seq.sv
// rtl/mips_alu_seq.sv - registered R-type ALU with iterative mul/div and HI/LO
// Single-cycle ops complete the edge after accept; mul/div stall issue until done.
module mips_alu_seq #(
   parameter int WIDTH = 32,
   parameter int SEL_W = 6
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [SEL_W-1:0] i_alu_sel,
   output logic             o_out_valid,
   output logic [WIDTH-1:0] o_result,
   output logic             o_zflag,
   output logic             o_ovf,
   output logic             o_div0,
   output logic             o_illegal,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);
   import mips_alu_pkg::*;

   localparam int SH_W = $clog2(WIDTH);

   logic             r_out_valid, r_zflag, r_ovf, r_div0, r_illegal;
   logic [WIDTH-1:0] r_result, r_hi, r_lo;

   logic             w_idle, w_accept, w_is_md, w_ovf, w_illegal;
   logic             w_md_done, w_md_div0;
   logic [WIDTH-1:0] w_res, w_sum, w_diff, w_md_hi, w_md_lo;
   logic [SH_W-1:0]  w_sh;

   assign w_accept = i_in_valid & w_idle;
   assign w_sum    = i_a + i_b;
   assign w_diff   = i_a - i_b;
   assign w_sh     = i_b[SH_W-1:0];

   always_comb begin
      w_res     = '0;
      w_ovf     = 1'b0;
      w_illegal = 1'b0;
      w_is_md   = 1'b0;
      case (i_alu_sel)
         FN_ADD: begin
            w_res = w_sum;
            w_ovf = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
         end
         FN_ADDU: w_res = w_sum;
         FN_SUB: begin
            w_res = w_diff;
            w_ovf = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
         end
         FN_SUBU: w_res = w_diff;
         FN_AND:  w_res = i_a & i_b;
         FN_OR:   w_res = i_a | i_b;
         FN_XOR:  w_res = i_a ^ i_b;
         FN_NOR:  w_res = ~(i_a | i_b);
         FN_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
         FN_SLTU: w_res = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
         FN_SLL:  w_res = i_a << w_sh;
         FN_SRL:  w_res = i_a >> w_sh;
         FN_SRA:  w_res = $unsigned($signed(i_a) >>> w_sh);
         FN_MFHI: w_res = r_hi;
         FN_MFLO: w_res = r_lo;
         FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: w_is_md = 1'b1;
         default: w_illegal = 1'b1;
      endcase
   end

   mips_muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_start (w_accept & w_is_md),
      .i_op    (i_alu_sel[1:0]),
      .i_a     (i_a),
      .i_b     (i_b),
      .o_idle  (w_idle),
      .o_done  (w_md_done),
      .o_hi    (w_md_hi),
      .o_lo    (w_md_lo),
      .o_div0  (w_md_div0)
   );

   // Flags and result only move on an out_valid cycle; otherwise they hold
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_zflag     <= 1'b0;
         r_ovf       <= 1'b0;
         r_div0      <= 1'b0;
         r_illegal   <= 1'b0;
         r_hi        <= '0;
         r_lo        <= '0;
      end else begin
         r_out_valid <= 1'b0;
         if (w_md_done) begin
            r_out_valid <= 1'b1;
            r_result    <= w_md_lo;
            r_zflag     <= (w_md_lo == '0);
            r_ovf       <= 1'b0;
            r_div0      <= w_md_div0;
            r_illegal   <= 1'b0;
            r_hi        <= w_md_hi;
            r_lo        <= w_md_lo;
         end else if (w_accept && !w_is_md) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_zflag     <= (w_res == '0);
            r_ovf       <= w_ovf;
            r_div0      <= 1'b0;
            r_illegal   <= w_illegal;
         end
      end
   end

   assign o_in_ready  = w_idle;
   assign o_out_valid = r_out_valid;
   assign o_result    = r_result;
   assign o_zflag     = r_zflag;
   assign o_ovf       = r_ovf;
   assign o_div0      = r_div0;
   assign o_illegal   = r_illegal;
   assign o_hi        = r_hi;
   assign o_lo        = r_lo;

endmodule
